// File: rtl/busca_instrucao.sv
// Instruction fetch unit: owns the PC, reads the program ROM and hands words to decode via valid/ready.
// Optional halt on the null opcode 0x00 when BUSCA_PARADA_EN is defined.
module busca_instrucao #(
    parameter int unsigned TAM_MEM = 32,
    parameter int unsigned LARGURA = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               iniciar,
    input  logic               salto_valido,
    input  logic [7:0]         salto_endereco,
    output logic [7:0]         ler_endereco,
    input  logic [LARGURA-1:0] instrucao_in,
    output logic [LARGURA-1:0] instrucao_out,
    output logic [7:0]         pc_out,
    output logic               valido,
    input  logic               pronto,
    output logic               parado
);

    localparam int unsigned AW = (TAM_MEM > 1) ? $clog2(TAM_MEM) : 1;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        BUSCANDO = 2'd1,
        PARADO   = 2'd2
    } estado_t;

    estado_t            estado, estado_nxt;
    logic [AW-1:0]      pc, pc_nxt;
    logic [LARGURA-1:0] instrucao_nxt;
    logic [7:0]         pc_out_nxt;
    logic               valido_nxt;
    logic               parado_nxt;

    // Jump target bits above the ROM address range are deliberately dropped.
    if (AW < 8) begin : g_salto_hi
        logic unused_salto_hi;
        assign unused_salto_hi = ^salto_endereco[7:AW];
    end

    assign ler_endereco = 8'(pc);

    always_ff @(posedge clk) begin
        if (reset) begin
            estado        <= OCIOSO;
            pc            <= '0;
            instrucao_out <= '0;
            pc_out        <= '0;
            valido        <= 1'b0;
            parado        <= 1'b0;
        end else begin
            estado        <= estado_nxt;
            pc            <= pc_nxt;
            instrucao_out <= instrucao_nxt;
            pc_out        <= pc_out_nxt;
            valido        <= valido_nxt;
            parado        <= parado_nxt;
        end
    end

    always_comb begin
        estado_nxt    = estado;
        pc_nxt        = pc;
        instrucao_nxt = instrucao_out;
        pc_out_nxt    = pc_out;
        valido_nxt    = valido;
        parado_nxt    = parado;

        // A completed handshake frees the slot unless a capture refills it below.
        if (valido && pronto) begin
            valido_nxt = 1'b0;
        end

        case (estado)
            OCIOSO: begin
                if (iniciar) begin
                    estado_nxt = BUSCANDO;
                    pc_nxt     = '0;
                end
            end

            BUSCANDO: begin
                if (salto_valido) begin
                    pc_nxt     = salto_endereco[AW-1:0];
                    valido_nxt = 1'b0;
                end else if (!valido || pronto) begin
                    instrucao_nxt = instrucao_in;
                    pc_out_nxt    = 8'(pc);
                    valido_nxt    = 1'b1;
                    pc_nxt        = pc + AW'(1);
`ifdef BUSCA_PARADA_EN
                    if (instrucao_in == '0) begin
                        estado_nxt = PARADO;
                        parado_nxt = 1'b1;
                        pc_nxt     = pc;
                    end
`endif
                end
            end

            PARADO: begin
                if (iniciar) begin
                    estado_nxt = BUSCANDO;
                    pc_nxt     = '0;
                    valido_nxt = 1'b0;
                    parado_nxt = 1'b0;
                end
            end

            default: begin
                estado_nxt = OCIOSO;
            end
        endcase
    end

endmodule
